cop0_ext: RTL and testbench
===========================

# cop0_ext

Parametrised system-control coprocessor (CP0) for the scalar core. It holds Status, Cause, EPC and BadVAddr, plus an optional Count/Compare timer and a read-only PRId. It raises the exception request from maskable interrupt lines or from synchronous faults. It sits in the scalar pipeline's execute stage and serves mfc0/mtc0/eret, stalling the pipeline for a configurable read latency.

## Interface
- NUM_INT, 6: hardware interrupt lines, legal 1..6, mapped to Cause.IP[2 .. NUM_INT+1] (bits 10 .. NUM_INT+9).
- READ_LATENCY, 1: cycles `stalled` is held per mfc0, legal 1..3.
- PRID, 32'h0000_0001: constant returned for register 15.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- stalled  out  1  pipeline stall request for the mfc0 in flight.
- exception  out  1  take exception/interrupt this cycle.
- read_addr  in  5  CP0 register read by mfc0.
- dest_addr  in  5  CP0 register written by mtc0.
- fromcpu  in  32  mtc0 write data.
- fromcpu_en  in  1  mtc0 write strobe.
- tocpu  out  32  mfc0 read data, registered.
- tocpu_en  in  1  mfc0 request, held by the pipeline while stalled.
- epc_in  in  32  PC of the faulting or interrupted instruction.
- int_req  in  NUM_INT  level-sensitive hardware interrupts.
- exc_valid  in  1  synchronous fault, unmaskable.
- exc_code_in  in  5  ExcCode of that fault.
- eret  in  1  return-from-exception strobe.
- status  out  32  Status register.
- badvaddr_in  in  32  faulting address; badvaddr_we  in  1  its write strobe.

## Operation
- Register map:
  - 8 BadVAddr
  - 9 Count
  - 11 Compare
  - 12 Status
  - 13 Cause
  - 14 EPC
  - 15 PRId
  - Any other address reads as Status. Writes to 15, to unmapped addresses, and (timer compiled out) to 9/11 are ignored.
- `pending` = Cause.IP & Status.IM (bits 15:8). `exception` = exc_valid | (Status[0] & |pending). Combinational, same cycle.
- Status:
  - mtc0 12 writes all 32 bits.
  - else on exception, Status[5:0] <= {Status[3:0],2'b00} (push KU/IE).
  - else on eret, Status[5:0] <= {Status[5:4],Status[5:2]} (pop).
- Cause:
  - IP[1:0] (bits 9:8) are software bits, written only by mtc0 13. All other bits ignore mtc0.
  - IP[NUM_INT+1:2] <= int_req every cycle. Unused IP bits read 0, except bit 15 when the timer is present.
  - ExcCode (bits 6:2) is loaded on exception: exc_code_in if exc_valid, else 0 (interrupt).
- EPC: mtc0 14 has priority; else on exception, EPC <= epc_in.
- BadVAddr: mtc0 8 has priority; else badvaddr_we loads badvaddr_in.
- Read: tocpu <= mux(read_addr) every cycle.
- Stall counter `rc` (2 bits):
  - stalled = tocpu_en & (rc != READ_LATENCY).
  - rc increments while stalled; it clears when it reaches READ_LATENCY or when tocpu_en is low.
  - tocpu is valid in the first cycle with tocpu_en=1 and stalled=0.

## Timing
- Reset: every register 0, except Compare = 32'hFFFF_FFFF. tocpu = 0, rc = 0, stalled follows tocpu_en.
- mfc0 occupies READ_LATENCY+1 cycles. The back-to-back second request begins its own count.
- Reset mid-read: rc clears. stalled re-asserts if tocpu_en is still high.
- Same-cycle priorities:
  - exception beats eret.
  - mtc0 beats any hardware update of the same register.
  - An mtc0 to Status or Cause in cycle N affects `exception` from cycle N+1.

## Configuration
- COP0_TIMER_EN defined:
  - Count increments every cycle and wraps at 2^32.
  - mtc0 9 loads Count, and that write replaces the increment.
  - Timer flag (Cause bit 15) sets the cycle after Count == Compare.
  - The flag is sticky until an mtc0 11, which clears it; a clear in the same cycle as a match wins.
- COP0_TIMER_EN undefined: no Count/Compare logic. Registers 9 and 11 read as Status. Cause bit 15 is 0.

## Test plan
- Reset, then mfc0 12 with READ_LATENCY=2 -> stalled high for exactly 2 cycles, tocpu = 0 on release.
- mtc0 12 = 32'h0000_0401, int_req[0]=1 -> exception=1 the next cycle, Status[5:0]=6'b000100, EPC=epc_in, ExcCode=0.
- exc_valid=1 with exc_code_in=5'd4, Status=0 -> exception=1, ExcCode=4, badvaddr_we loads 32'hDEAD_BEEF.
- Exception and eret in the same cycle, Status[5:0]=6'b000011 -> Status[5:0]=6'b001100.
- Timer build: Compare=10, Count=5 -> Cause[15]=1 six cycles later; with Status=32'h0000_8001, exception asserts; mtc0 11 clears Cause[15].
- mtc0 14 concurrent with exception -> EPC = fromcpu, not epc_in.

Source files
------------

// File: rtl/cop0_ext.sv
// cop0_ext: system-control coprocessor (CP0) for the scalar core.
// Holds Status, Cause, EPC, BadVAddr and a read-only PRId, raises the
// exception request and serves mfc0/mtc0/eret with a stalled read.
// Optional Count/Compare timer is built when COP0_TIMER_EN is defined.
module cop0_ext #(
  parameter int          NUM_INT      = 6,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] PRID         = 32'h0000_0001
) (
  input  logic               clk,
  input  logic               resetn,
  output logic               stalled,
  output logic               exception,
  input  logic [4:0]         read_addr,
  input  logic [4:0]         dest_addr,
  input  logic [31:0]        fromcpu,
  input  logic               fromcpu_en,
  output logic [31:0]        tocpu,
  input  logic               tocpu_en,
  input  logic [31:0]        epc_in,
  input  logic [NUM_INT-1:0] int_req,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code_in,
  input  logic               eret,
  output logic [31:0]        status,
  input  logic [31:0]        badvaddr_in,
  input  logic               badvaddr_we
);

  localparam logic [1:0] RL = 2'(READ_LATENCY);

  logic [31:0]        status_q;
  logic [31:0]        epc_q;
  logic [31:0]        badvaddr_q;
  logic [1:0]         ip_sw_q;
  logic [NUM_INT-1:0] ip_hw_q;
  logic [4:0]         exc_code_q;
  logic [1:0]         rc;
  logic [31:0]        cause_val;
  logic [31:0]        read_val;
  logic [7:0]         pending;

  logic wr_badvaddr;
  logic wr_status;
  logic wr_cause;
  logic wr_epc;

  assign wr_badvaddr = fromcpu_en && (dest_addr == 5'd8);
  assign wr_status   = fromcpu_en && (dest_addr == 5'd12);
  assign wr_cause    = fromcpu_en && (dest_addr == 5'd13);
  assign wr_epc      = fromcpu_en && (dest_addr == 5'd14);

`ifdef COP0_TIMER_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_flag_q;
  logic        wr_count;
  logic        wr_compare;

  assign wr_count   = fromcpu_en && (dest_addr == 5'd9);
  assign wr_compare = fromcpu_en && (dest_addr == 5'd11);

  // Free-running Count with mtc0 override, Compare register and sticky match flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q      <= '0;
      compare_q    <= 32'hFFFF_FFFF;
      timer_flag_q <= 1'b0;
    end else begin
      count_q <= wr_count ? fromcpu : count_q + 32'd1;
      if (wr_compare) begin
        compare_q    <= fromcpu;
        timer_flag_q <= 1'b0;
      end else if (count_q == compare_q) begin
        timer_flag_q <= 1'b1;
      end
    end
  end
`endif

  // Assemble the architectural Cause word; the timer shares IP bit 7 with the top line
  always_comb begin
    cause_val                 = '0;
    cause_val[9:8]            = ip_sw_q;
    cause_val[NUM_INT+9:10]   = ip_hw_q;
    cause_val[6:2]            = exc_code_q;
`ifdef COP0_TIMER_EN
    cause_val[15]             = cause_val[15] | timer_flag_q;
`endif
  end

  assign pending   = cause_val[15:8] & status_q[15:8];
  assign exception = exc_valid | (status_q[0] & (|pending));
  assign status    = status_q;
  assign stalled   = tocpu_en && (rc != RL);

  // Status: full mtc0 write, else push KU/IE on exception, else pop on eret
  always_ff @(posedge clk) begin
    if (!resetn) begin
      status_q <= '0;
    end else if (wr_status) begin
      status_q <= fromcpu;
    end else if (exception) begin
      status_q[5:0] <= {status_q[3:0], 2'b00};
    end else if (eret) begin
      status_q[5:0] <= {status_q[5:4], status_q[5:2]};
    end
  end

  // Cause: hardware IP sampled every cycle, software IP by mtc0, ExcCode on exception
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      exc_code_q <= '0;
    end else begin
      ip_hw_q <= int_req;
      if (wr_cause) ip_sw_q <= fromcpu[9:8];
      if (exception) exc_code_q <= exc_valid ? exc_code_in : 5'd0;
    end
  end

  // EPC and BadVAddr: software write wins over the hardware capture
  always_ff @(posedge clk) begin
    if (!resetn) begin
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      if (wr_epc) epc_q <= fromcpu;
      else if (exception) epc_q <= epc_in;
      if (wr_badvaddr) badvaddr_q <= fromcpu;
      else if (badvaddr_we) badvaddr_q <= badvaddr_in;
    end
  end

  // Read multiplexer; unmapped addresses fall back to Status
  always_comb begin
    read_val = status_q;
    case (read_addr)
      5'd8:  read_val = badvaddr_q;
`ifdef COP0_TIMER_EN
      5'd9:  read_val = count_q;
      5'd11: read_val = compare_q;
`endif
      5'd12: read_val = status_q;
      5'd13: read_val = cause_val;
      5'd14: read_val = epc_q;
      5'd15: read_val = PRID;
      default: read_val = status_q;
    endcase
  end

  // Registered mfc0 data, refreshed every cycle
  always_ff @(posedge clk) begin
    if (!resetn) tocpu <= '0;
    else         tocpu <= read_val;
  end

  // Read-latency counter: counts stall cycles, restarts after release or idle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rc <= '0;
    end else if (!tocpu_en || (rc == RL)) begin
      rc <= '0;
    end else begin
      rc <= rc + 2'd1;
    end
  end

endmodule

// File: tb/tb_cop0_ext.sv
// tb_cop0_ext: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against an architectural
// model of the CP0 registers held in the bench.
module tb_cop0_ext;

  localparam int          NUM_INT = 6;
  localparam int          RL      = 2;
  localparam logic [31:0] PRID    = 32'h0000_0001;

  logic               clk;
  logic               resetn;
  logic               stalled;
  logic               exception;
  logic [4:0]         read_addr;
  logic [4:0]         dest_addr;
  logic [31:0]        fromcpu;
  logic               fromcpu_en;
  logic [31:0]        tocpu;
  logic               tocpu_en;
  logic [31:0]        epc_in;
  logic [NUM_INT-1:0] int_req;
  logic               exc_valid;
  logic [4:0]         exc_code_in;
  logic               eret;
  logic [31:0]        status;
  logic [31:0]        badvaddr_in;
  logic               badvaddr_we;

  cop0_ext #(.NUM_INT(NUM_INT), .READ_LATENCY(RL), .PRID(PRID)) dut (
    .clk(clk), .resetn(resetn), .stalled(stalled), .exception(exception),
    .read_addr(read_addr), .dest_addr(dest_addr), .fromcpu(fromcpu),
    .fromcpu_en(fromcpu_en), .tocpu(tocpu), .tocpu_en(tocpu_en),
    .epc_in(epc_in), .int_req(int_req), .exc_valid(exc_valid),
    .exc_code_in(exc_code_in), .eret(eret), .status(status),
    .badvaddr_in(badvaddr_in), .badvaddr_we(badvaddr_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- architectural model ----------------
  bit          model_valid = 1'b0;
  logic [31:0] m_status, m_epc, m_bva, m_tocpu, m_count, m_compare;
  logic [1:0]  m_sw;
  logic [5:0]  m_irq;
  logic [4:0]  m_code;
  logic        m_flag;
  int          m_age;
  logic        n_exc, n_match;
  logic [31:0] n_rd;

  function automatic logic [31:0] m_cause();
    logic [5:0] hw;
    hw = m_irq;
`ifdef COP0_TIMER_EN
    hw[5] = hw[5] | m_flag;
`endif
    return {16'b0, hw, m_sw, 1'b0, m_code, 2'b00};
  endfunction

  function automatic logic m_exc();
    logic [31:0] c;
    logic [7:0]  p;
    c = m_cause();
    p = c[15:8] & m_status[15:8];
    return exc_valid | (m_status[0] & (p != 8'd0));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_bva;
`ifdef COP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      5'd13: return m_cause();
      5'd14: return m_epc;
      5'd15: return PRID;
      default: return m_status;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_status = '0; m_epc = '0; m_bva = '0; m_tocpu = '0; m_count = '0;
      m_compare = 32'hFFFF_FFFF; m_sw = '0; m_irq = '0; m_code = '0;
      m_flag = 1'b0; m_age = 0; model_valid = 1'b1;
    end else if (model_valid) begin
      n_exc   = m_exc();
      n_rd    = m_read(read_addr);
      n_match = (m_count == m_compare);
      if (fromcpu_en && dest_addr == 5'd12) m_status = fromcpu;
      else if (n_exc) m_status[5:0] = {m_status[3:0], 2'b00};
      else if (eret)  m_status[5:0] = {m_status[5:4], m_status[5:2]};
      if (fromcpu_en && dest_addr == 5'd13) m_sw = fromcpu[9:8];
      m_irq = int_req;
      if (n_exc) m_code = exc_valid ? exc_code_in : 5'd0;
      if (fromcpu_en && dest_addr == 5'd14) m_epc = fromcpu;
      else if (n_exc) m_epc = epc_in;
      if (fromcpu_en && dest_addr == 5'd8) m_bva = fromcpu;
      else if (badvaddr_we) m_bva = badvaddr_in;
`ifdef COP0_TIMER_EN
      if (fromcpu_en && dest_addr == 5'd9) m_count = fromcpu;
      else m_count = m_count + 32'd1;
      if (fromcpu_en && dest_addr == 5'd11) begin
        m_compare = fromcpu;
        m_flag    = 1'b0;
      end else if (n_match) begin
        m_flag = 1'b1;
      end
`endif
      m_tocpu = n_rd;
      m_age   = tocpu_en ? m_age + 1 : 0;
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("stalled", {31'b0, stalled},
                  {31'b0, tocpu_en && ((m_age % (RL + 1)) != RL)});
      checkOutput("exception", {31'b0, exception}, {31'b0, m_exc()});
      checkOutput("status", status, m_status);
      checkOutput("tocpu", tocpu, m_tocpu);
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    read_addr = 5'd0; dest_addr = 5'd0; fromcpu = '0; fromcpu_en = 1'b0;
    tocpu_en = 1'b0; epc_in = '0; int_req = '0; exc_valid = 1'b0;
    exc_code_in = '0; eret = 1'b0; badvaddr_in = '0; badvaddr_we = 1'b0;
  endtask

  logic [4:0] dest_pick [9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3, 5'd0};

  initial begin
    idleInputs();
    resetn = 1'b0;
    applyStimulus();
    applyStimulus();

    // reset state and mfc0 stall timing, with the read starting under reset
    tocpu_en = 1'b1;
    #1;
    checkOutput("rst_stall", {31'b0, stalled}, 32'd1);
    checkOutput("rst_tocpu", tocpu, 32'd0);
    checkOutput("rst_status", status, 32'd0);
    applyStimulus();
    resetn = 1'b1; read_addr = 5'd12; tocpu_en = 1'b1;
    #1 checkOutput("rd_stall0", {31'b0, stalled}, 32'd1);
    applyStimulus();
    #1 checkOutput("rd_stall1", {31'b0, stalled}, 32'd1);
    applyStimulus();
    #1 checkOutput("rd_release", {31'b0, stalled}, 32'd0);
    checkOutput("rd_data", tocpu, 32'd0);
    applyStimulus();
    #1 checkOutput("rd_b2b", {31'b0, stalled}, 32'd1);
    tocpu_en = 1'b0;
    applyStimulus();

    // masked interrupt enabled by mtc0 takes effect one cycle later
    fromcpu_en = 1'b1; dest_addr = 5'd12; fromcpu = 32'h0000_0401; int_req = 6'd1;
    #1 checkOutput("im_before", {31'b0, exception}, 32'd0);
    applyStimulus();
    fromcpu_en = 1'b0; epc_in = 32'h1234_5678;
    #1 checkOutput("irq_exc", {31'b0, exception}, 32'd1);
    applyStimulus();
    read_addr = 5'd14;
    #1 checkOutput("irq_push", {26'b0, status[5:0]}, 32'h0000_0004);
    checkOutput("irq_exc_off", {31'b0, exception}, 32'd0);
    applyStimulus();
    read_addr = 5'd13;
    #1 checkOutput("irq_epc", tocpu, 32'h1234_5678);
    applyStimulus();
    int_req = '0;
    #1 checkOutput("irq_cause", tocpu, 32'h0000_0400);

    // synchronous fault with BadVAddr capture
    fromcpu_en = 1'b1; dest_addr = 5'd12; fromcpu = 32'd0;
    applyStimulus();
    fromcpu_en = 1'b0; exc_valid = 1'b1; exc_code_in = 5'd4;
    badvaddr_we = 1'b1; badvaddr_in = 32'hDEAD_BEEF; epc_in = 32'h0000_0100;
    #1 checkOutput("fault_exc", {31'b0, exception}, 32'd1);
    applyStimulus();
    exc_valid = 1'b0; badvaddr_we = 1'b0; read_addr = 5'd13;
    applyStimulus();
    read_addr = 5'd8;
    #1 checkOutput("fault_code", tocpu, 32'h0000_0010);
    applyStimulus();
    #1 checkOutput("fault_bva", tocpu, 32'hDEAD_BEEF);

    // exception and eret together: the push wins
    fromcpu_en = 1'b1; dest_addr = 5'd12; fromcpu = 32'h0000_0003;
    applyStimulus();
    fromcpu_en = 1'b0; exc_valid = 1'b1; exc_code_in = 5'd0; eret = 1'b1;
    applyStimulus();
    exc_valid = 1'b0; eret = 1'b0;
    #1 checkOutput("exc_eret", status, 32'h0000_000C);

    // mtc0 EPC beats the exception capture
    fromcpu_en = 1'b1; dest_addr = 5'd14; fromcpu = 32'hCAFE_0000;
    exc_valid = 1'b1; exc_code_in = 5'd8; epc_in = 32'h0000_0200;
    applyStimulus();
    fromcpu_en = 1'b0; exc_valid = 1'b0; read_addr = 5'd14;
    applyStimulus();
    read_addr = 5'd15;
    #1 checkOutput("epc_mtc0", tocpu, 32'hCAFE_0000);
    applyStimulus();
    read_addr = 5'd9;
    #1 checkOutput("prid", tocpu, PRID);
    applyStimulus();
`ifdef COP0_TIMER_EN
    // timer: Compare=10, Count=5, IM7 and IE enabled
    fromcpu_en = 1'b1; dest_addr = 5'd11; fromcpu = 32'd10;
    applyStimulus();
    dest_addr = 5'd12; fromcpu = 32'h0000_8001;
    applyStimulus();
    dest_addr = 5'd9; fromcpu = 32'd5;
    applyStimulus();
    fromcpu_en = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus();
    #1 checkOutput("timer_pre", {31'b0, exception}, 32'd0);
    applyStimulus();
    read_addr = 5'd13;
    #1 checkOutput("timer_exc", {31'b0, exception}, 32'd1);
    applyStimulus();
    fromcpu_en = 1'b1; dest_addr = 5'd11; fromcpu = 32'hFFFF_FFFF;
    #1 checkOutput("timer_flag", {31'b0, tocpu[15]}, 32'd1);
    applyStimulus();
    fromcpu_en = 1'b0;
    applyStimulus();
    #1 checkOutput("timer_clear", {31'b0, tocpu[15]}, 32'd0);
`else
    #1 checkOutput("unmapped9", tocpu, 32'h0000_0030);
`endif

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      resetn      = ($urandom_range(0, 99) != 0);
      tocpu_en    = ($urandom_range(0, 3) != 0);
      read_addr   = 5'($urandom_range(0, 31));
      fromcpu_en  = ($urandom_range(0, 3) == 0);
      dest_addr   = dest_pick[$urandom_range(0, 8)];
      fromcpu     = $urandom();
      int_req     = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : 6'd0;
      exc_valid   = ($urandom_range(0, 7) == 0);
      exc_code_in = 5'($urandom());
      eret        = ($urandom_range(0, 7) == 0);
      epc_in      = $urandom();
      badvaddr_we = ($urandom_range(0, 3) == 0);
      badvaddr_in = $urandom();
    end
    applyStimulus();
    idleInputs();
    applyStimulus();
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
